// File: rtl/add_seq.sv
// Byte-serial multi-byte adder: feeds one byte pair per cycle to an external 8-bit adder and rippling the carry.
// Optional build macro ADD_SEQ_SUB_EN adds a 'sub' input that turns the operation into op_a - op_b.
module add_seq #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] op_a,
  input  logic [8*NBYTES-1:0] op_b,
  input  logic                cin,
`ifdef ADD_SEQ_SUB_EN
  input  logic                sub,
`endif
  output logic [7:0]          add_a,
  output logic [7:0]          add_b,
  output logic                add_ci,
  input  logic [7:0]          add_x,
  input  logic                add_co,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] sum,
  output logic                cout,
  output logic [1:0]          dbg_state
);

  localparam int W  = 8*NBYTES;
  localparam int IW = $clog2(NBYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  sum_q;
  logic          carry;
  logic          cout_q;
  logic          sub_q;
  logic          init_carry;
  logic [7:0]    a_byte;
  logic [7:0]    b_byte;
  logic          accept;
  logic          last;
  logic          fire_out;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; in_ready depends only on state, and out_valid/sum/cout stay
  // stable until out_ready is seen.
  assign accept   = in_valid && (state == IDLE);
  assign fire_out = out_ready && (state == DONE);
  assign last     = (idx == IW'(NBYTES-1));

`ifdef ADD_SEQ_SUB_EN
  // Subtraction is a + ~b + 1, so the incoming carry is forced high.
  assign init_carry = sub | cin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q <= 1'b0;
    end else if (accept) begin
      sub_q <= sub;
    end
  end
`else
  assign init_carry = cin;
  assign sub_q      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (fire_out) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    a_byte = '0;
    b_byte = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx == IW'(i)) begin
        a_byte = a_q[8*i +: 8];
        b_byte = b_q[8*i +: 8];
      end
    end
  end

  // Adder-stage operands are only live in RUN so the external adder sees zeros otherwise.
  always_comb begin
    add_a  = '0;
    add_b  = '0;
    add_ci = 1'b0;
    if (state == RUN) begin
      add_a  = a_byte;
      add_b  = b_byte ^ {8{sub_q}};
      add_ci = carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (accept) begin
      a_q   <= op_a;
      b_q   <= op_b;
      idx   <= '0;
      carry <= init_carry;
    end else if (state == RUN) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (idx == IW'(i)) sum_q[8*i +: 8] <= add_x;
      end
      carry <= add_co;
      idx   <= last ? '0 : idx + IW'(1);
      if (last) cout_q <= add_co;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_add_seq.sv
// Bench for add_seq: ideal 8-bit adder attached, arithmetic reference model with expected queue.
module tb_add_seq;
  localparam int NBYTES = 4;
  localparam int W      = 8*NBYTES;
`ifdef ADD_SEQ_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         cin = 1'b0;
  logic         sub_drv = 1'b0;
  logic [7:0]   add_a, add_b, add_x;
  logic         add_ci, add_co;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic [1:0]   dbg_state;

  add_seq #(.NBYTES(NBYTES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .cin(cin),
`ifdef ADD_SEQ_SUB_EN
    .sub(sub_drv),
`endif
    .add_a(add_a), .add_b(add_b), .add_ci(add_ci), .add_x(add_x), .add_co(add_co),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
    .dbg_state(dbg_state)
  );

  // Ideal downstream 8-bit adder.
  assign {add_co, add_x} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_ci};

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard state
  logic [W:0]   exp_q[$];
  int           acc_edges[$];
  int           n_vec = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           last_acc = 0;
  int           run_i = -1;
  bit           accepted = 1'b0;
  logic         ov_prev = 1'b0;
  logic [W-1:0] cur_a, cur_b;
  logic         cur_c;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Observe the settled state at a falling edge, then advance one clock.
  task automatic step();
    logic [63:0] m;
    logic [63:0] c;
    logic [W:0]  e;
    if (rst_n && run_i >= 0) begin
      check("add_a", 64'(add_a), (64'(cur_a) >> (8*run_i)) & 64'hFF);
      check("add_b", 64'(add_b), (64'(cur_b) >> (8*run_i)) & 64'hFF);
      m = (64'd1 << (8*run_i)) - 64'd1;
      c = ((64'(cur_a) & m) + (64'(cur_b) & m) + 64'(cur_c)) >> (8*run_i);
      check("add_ci", 64'(add_ci), c & 64'd1);
      check("in_ready_busy", 64'(in_ready), 64'd0);
      run_i++;
      if (run_i == NBYTES) run_i = -1;
    end
    accepted = 1'b0;
    if (rst_n && in_valid && in_ready) begin
      accepted = 1'b1;
      cur_a = op_a;
      cur_b = sub_drv ? ~op_b : op_b;
      cur_c = sub_drv ? 1'b1 : cin;
      e = {1'b0, cur_a} + {1'b0, cur_b} + (W+1)'(cur_c);
      exp_q.push_back(e);
      acc_edges.push_back(cyc);
      last_acc = cyc;
      run_i = 0;
    end
    if (rst_n && out_valid && !ov_prev) begin
      check("latency", 64'(cyc - 1 - last_acc), 64'(NBYTES));
      check("add_a_done", 64'({add_a, add_b, add_ci}), 64'd0);
    end
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("sum", 64'(sum), 64'(e[W-1:0]));
        check("cout", 64'(cout), 64'(e[W]));
      end
    end
    ov_prev = out_valid;
    @(negedge clk);
    cyc++;
  endtask

  // Driver: present an operation until accepted, then scramble the operand pins.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input logic sb);
    int n;
    n = 0;
    op_a = a; op_b = b; cin = ci; sub_drv = sb & SUB_EN; in_valid = 1'b1;
    do begin
      step();
      n++;
    end while (!accepted && n < 50);
    if (!accepted) check("accept_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
    op_a = W'($urandom);
    op_b = W'($urandom);
    cin = 1'($urandom_range(0, 1));
    sub_drv = SUB_EN ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  // Driver: wait for the result, stall it for 'hold' cycles, then take it.
  task automatic drain(input int hold);
    int           n;
    logic [W-1:0] s0;
    logic         c0;
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    if (!out_valid) begin
      check("out_timeout", 64'd0, 64'd1);
    end else begin
      s0 = sum;
      c0 = cout;
      repeat (hold) begin
        step();
        check("hold_sum", 64'(sum), 64'(s0));
        check("hold_cout", 64'(cout), 64'(c0));
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_in_ready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("idle_after_pop", 64'(in_ready), 64'd1);
      check("valid_after_pop", 64'(out_valid), 64'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sum"}, 64'(sum), 64'd0);
    check({tag, "_cout"}, 64'(cout), 64'd0);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_add"}, 64'({add_a, add_b, add_ci}), 64'd0);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  logic [W-1:0] tp_a[3];
  logic [W-1:0] tp_b[3];

  initial begin
    int k;
    int n;
    // Reset state
    #1;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Case 1: byte carry into the second byte
    send(32'h000000FF, 32'h00000001, 1'b0, 1'b0);
    drain(0);
    check("c1_sum", 64'(sum), 64'h00000100);
    check("c1_cout", 64'(cout), 64'd0);

    // Case 2: carry-in ripples through every byte and overflows
    send(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0);
    drain(1);
    check("c2_sum", 64'(sum), 64'h00000000);
    check("c2_cout", 64'(cout), 64'd1);

    // Case 3: back-pressure for three cycles
    send(32'h12345678, 32'h11111111, 1'b0, 1'b0);
    drain(3);
    check("c3_sum", 64'(sum), 64'h23456789);

    // Case 4: reset after two bytes of RUN
    send(32'hA5A5A5A5, 32'h5A5A5A5B, 1'b0, 1'b0);
    step();
    step();
    #1 rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    exp_q.delete();
    run_i = -1;
    ov_prev = 1'b0;
    @(negedge clk);
    cyc++;
    rst_n = 1'b1;
    check("rst_release_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (10) begin
      step();
      check("no_valid_after_rst", 64'(out_valid), 64'd0);
    end
    out_ready = 1'b0;

`ifdef ADD_SEQ_SUB_EN
    // Case 5: subtraction with and without borrow
    send(32'h00000005, 32'h00000007, 1'b0, 1'b1);
    drain(0);
    check("c5_sum_a", 64'(sum), 64'hFFFFFFFE);
    check("c5_cout_a", 64'(cout), 64'd0);
    send(32'h00000007, 32'h00000005, 1'b1, 1'b1);
    drain(0);
    check("c5_sum_b", 64'(sum), 64'h00000002);
    check("c5_cout_b", 64'(cout), 64'd1);
`endif

    // Case 6: streaming throughput
    tp_a[0] = 32'h00000001; tp_b[0] = 32'h00000002;
    tp_a[1] = 32'h80000000; tp_b[1] = 32'h80000000;
    tp_a[2] = 32'h0000FFFF; tp_b[2] = 32'h00000001;
    acc_edges.delete();
    k = 0;
    n = 0;
    op_a = tp_a[0]; op_b = tp_b[0]; cin = 1'b0; sub_drv = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    while ((k < 3 || exp_q.size() > 0) && n < 100) begin
      step();
      n++;
      if (accepted) begin
        k++;
        if (k < 3) begin
          op_a = tp_a[k];
          op_b = tp_b[k];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    out_ready = 1'b0;
    check("tp_accepts", 64'(acc_edges.size()), 64'd3);
    if (acc_edges.size() == 3) begin
      check("tp_gap0", 64'(acc_edges[1] - acc_edges[0]), 64'(NBYTES + 2));
      check("tp_gap1", 64'(acc_edges[2] - acc_edges[1]), 64'(NBYTES + 2));
    end
    check("tp_last_sum", 64'(sum), 64'h00010000);

    // Randomized operations with random back-pressure
    send(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
    drain(0);
    for (int i = 0; i < 24; i++) begin
      send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
           SUB_EN ? 1'($urandom_range(0, 1)) : 1'b0);
      drain($urandom_range(0, 3));
    end
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
